// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the multiplexed BCD wall clock.
// Sequences RUN -> edit hours -> edit minutes -> commit, holds the edited time,
// and drives the timekeeper count enable, load strobe and display blink mask.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   btn_mode, btn_inc                 debounced button levels (active high)
//   sec_tick                          one-cycle pulse per second
//   cur_{min_u,min_d,hrs_u,hrs_d}     live BCD time from the timekeeper
//   set_{min_u,min_d,hrs_u,hrs_d}     edited BCD time
//   load                              one-cycle strobe: timekeeper copies set_*
//   run                               timekeeper count enable
//   blank_mask                        {hrs_d, hrs_u, min_d, min_u} blanking
//   mode                              0=RUN 1=EDIT_HRS 2=EDIT_MIN 3=COMMIT
`timescale 1ns/1ps

module clock_set_ctrl #(
    parameter int unsigned CLK_HZ    = 27000000,
    parameter int unsigned BLINK_HZ  = 2,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_tick,
    input  logic [3:0] cur_min_u,
    input  logic [3:0] cur_min_d,
    input  logic [3:0] cur_hrs_u,
    input  logic [3:0] cur_hrs_d,
    output logic [3:0] set_min_u,
    output logic [3:0] set_min_d,
    output logic [3:0] set_hrs_u,
    output logic [3:0] set_hrs_d,
    output logic       load,
    output logic       run,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);

    localparam int unsigned HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(HALF_PERIOD - 1);
    localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT_S);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EDIT_HRS = 2'd1,
        ST_EDIT_MIN = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          set_q, set_nxt;      // {hrs_d, hrs_u, min_d, min_u}
    logic [7:0]           idle_cnt, idle_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_nxt;
    logic                 phase, phase_nxt;
    logic                 btn_mode_q, btn_inc_q;
    logic                 mode_edge, inc_edge;
    logic                 in_edit, enter_edit;
    logic [3:0]           blank_nxt;

    // BCD hour increment 0..23; anything invalid restarts at 00
    function automatic logic [7:0] inc_hrs(input logic [3:0] d, input logic [3:0] u);
        if (d > 4'd2 || u > 4'd9 || (d == 4'd2 && u >= 4'd3)) return 8'h00;
        else if (u == 4'd9)                                   return {d + 4'd1, 4'd0};
        else                                                  return {d, u + 4'd1};
    endfunction

    // BCD minute increment 0..59, no carry out; invalid restarts at 00
    function automatic logic [7:0] inc_min(input logic [3:0] d, input logic [3:0] u);
        if (d > 4'd5 || u > 4'd9 || (d == 4'd5 && u == 4'd9)) return 8'h00;
        else if (u == 4'd9)                                   return {d + 4'd1, 4'd0};
        else                                                  return {d, u + 4'd1};
    endfunction

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc  & ~btn_inc_q;
    assign in_edit   = (state == ST_EDIT_HRS) || (state == ST_EDIT_MIN);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state and next datapath values
    always_comb begin
        state_nxt = state;
        set_nxt   = set_q;
        unique case (state)
            ST_RUN: begin
                if (mode_edge) begin
                    state_nxt = ST_EDIT_HRS;
                    set_nxt   = {cur_hrs_d, cur_hrs_u, cur_min_d, cur_min_u};
                end
            end
            ST_EDIT_HRS, ST_EDIT_MIN: begin
                // mode beats inc; any edge suppresses the timeout this cycle
                if (mode_edge) begin
                    state_nxt = (state == ST_EDIT_HRS) ? ST_EDIT_MIN : ST_COMMIT;
                end else if (inc_edge) begin
                    if (state == ST_EDIT_HRS) set_nxt[15:8] = inc_hrs(set_q[15:12], set_q[11:8]);
                    else                      set_nxt[7:0]  = inc_min(set_q[7:4], set_q[3:0]);
                end else if (sec_tick && (idle_cnt + 8'd1) == TIMEOUT_CNT) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase

        enter_edit = (state_nxt != state) &&
                     ((state_nxt == ST_EDIT_HRS) || (state_nxt == ST_EDIT_MIN));

        idle_nxt = idle_cnt;
        if (enter_edit || mode_edge || inc_edge) idle_nxt = 8'd0;
        else if (sec_tick && in_edit)            idle_nxt = idle_cnt + 8'd1;

        // Blink restarts visible on entry and after every increment
        blink_nxt = blink_cnt + BLINK_W'(1);
        phase_nxt = phase;
        if (enter_edit || inc_edge) begin
            blink_nxt = '0;
            phase_nxt = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
        end

        unique case (state_nxt)
            ST_EDIT_HRS: blank_nxt = {phase_nxt, phase_nxt, 2'b00};
            ST_EDIT_MIN: blank_nxt = {2'b00, phase_nxt, phase_nxt};
            default:     blank_nxt = 4'b0000;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            set_q      <= 16'h0000;
            idle_cnt   <= 8'd0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
            run        <= 1'b1;
            load       <= 1'b0;
            blank_mask <= 4'b0000;
        end else begin
            set_q      <= set_nxt;
            idle_cnt   <= idle_nxt;
            blink_cnt  <= blink_nxt;
            phase      <= phase_nxt;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            run        <= (state_nxt == ST_RUN);
            load       <= (state_nxt == ST_COMMIT);
            blank_mask <= blank_nxt;
        end
    end

    assign mode      = state;
    assign set_hrs_d = set_q[15:12];
    assign set_hrs_u = set_q[11:8];
    assign set_min_d = set_q[7:4];
    assign set_min_u = set_q[3:0];

endmodule
